// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants and types for the UART command decoder.
// Command bytes, echo FSM states and the op decode helper.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_SEC   = 8'h73;
  localparam logic [7:0] CMD_MIN   = 8'h6D;
  localparam logic [7:0] CMD_HOUR  = 8'h68;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STOP  = 8'h53;
  localparam logic [7:0] CMD_CLEAR = 8'h43;
  localparam logic [7:0] CMD_WMODE = 8'h57;
  localparam logic [7:0] CMD_FMODE = 8'h46;

  localparam logic [7:0] ERR_CHAR  = 8'h3F;

  typedef enum logic [1:0] {
    ECHO_IDLE,
    ECHO_WAIT_FREE,
    ECHO_START,
    ECHO_HOLD
  } echo_state_e;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_SEC,
    OP_MIN,
    OP_HOUR,
    OP_RUN,
    OP_STOP,
    OP_CLEAR,
    OP_WMODE,
    OP_FMODE
  } cmd_op_e;

  function automatic cmd_op_e decode_cmd(
    input logic [7:0] b
  );
    case (b)
      CMD_SEC:   return OP_SEC;
      CMD_MIN:   return OP_MIN;
      CMD_HOUR:  return OP_HOUR;
      CMD_RUN:   return OP_RUN;
      CMD_STOP:  return OP_STOP;
      CMD_CLEAR: return OP_CLEAR;
      CMD_WMODE: return OP_WMODE;
      CMD_FMODE: return OP_FMODE;
      default:   return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// UART side of the command decoder: rx strobe/byte in,
// tx busy/start handshake with the byte to send.
interface uart_cmd_decoder_if;

  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       i_tx_busy;
  logic [7:0] o_tx_data;
  logic       o_tx_start;

  modport master (
    output i_rx_data,
    output i_rx_done,
    output i_tx_busy,
    input  o_tx_data,
    input  o_tx_start
  );

  modport slave (
    input  i_rx_data,
    input  i_rx_done,
    input  i_tx_busy,
    output o_tx_data,
    output o_tx_start
  );

endinterface

// File: rtl/uart_cmd_decoder_echo.sv
// Echo controller: one-entry pending buffer and the
// busy/start handshake towards the UART transmitter.
module cmd_echo_ctrl
  import uart_cmd_pkg::*;
#(
  parameter bit ECHO_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] req_byte,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start
);

  echo_state_e state_q;
  logic        pend_v;
  logic [7:0]  pend_b;
  logic [7:0]  data_q;
  logic        start_q;
  logic        seen_busy;
  logic [1:0]  hold_cnt;
  logic        req_en;

  assign req_en = req & ECHO_EN;

  // A start pulse must never reach a busy transmitter.
  assign tx_start = start_q & ~tx_busy & ECHO_EN;
  assign tx_data  = ECHO_EN ? data_q : 8'h00;

  // Pending buffer plus echo FSM; new echoes drop while full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ECHO_IDLE;
      pend_v    <= 1'b0;
      pend_b    <= 8'h00;
      data_q    <= 8'h00;
      start_q   <= 1'b0;
      seen_busy <= 1'b0;
      hold_cnt  <= 2'd0;
    end else begin
      start_q <= 1'b0;
      if (req_en && !pend_v) begin
        pend_v <= 1'b1;
        pend_b <= req_byte;
      end
      unique case (state_q)
        ECHO_IDLE: begin
          if (pend_v) state_q <= ECHO_WAIT_FREE;
        end
        ECHO_WAIT_FREE: begin
          if (!tx_busy) begin
            data_q  <= pend_b;
            pend_v  <= 1'b0;
            start_q <= 1'b1;
            state_q <= ECHO_START;
          end
        end
        ECHO_START: begin
          seen_busy <= 1'b0;
          hold_cnt  <= 2'd0;
          state_q   <= ECHO_HOLD;
        end
        ECHO_HOLD: begin
          hold_cnt <= hold_cnt + 2'd1;
          if (tx_busy) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            state_q <= ECHO_IDLE;
          end else if (hold_cnt == 2'd3) begin
            state_q <= ECHO_IDLE;
          end
        end
        default: state_q <= ECHO_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder: control pulses, mode register,
// error counter, and echo of every received byte.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter bit         ECHO_EN  = 1'b1,
  parameter logic [7:0] ERR_CHAR = uart_cmd_pkg::ERR_CHAR
) (
  input  logic                clk,
  input  logic                rst,
  uart_cmd_decoder_if.slave   uart,
  output logic                o_sec_plus,
  output logic                o_min_plus,
  output logic                o_hour_plus,
  output logic                o_run,
  output logic                o_stop,
  output logic                o_clear,
  output logic [1:0]          o_mode_sel,
  output logic [7:0]          o_err_cnt
);

  cmd_op_e    op;
  logic       known;
  logic [7:0] echo_byte;

  assign op        = decode_cmd(uart.i_rx_data);
  assign known     = (op != OP_NONE);
  assign echo_byte = known ? uart.i_rx_data : ERR_CHAR;

  // Registered one-cycle pulses, mode toggles, error count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_sec_plus  <= 1'b0;
      o_min_plus  <= 1'b0;
      o_hour_plus <= 1'b0;
      o_run       <= 1'b0;
      o_stop      <= 1'b0;
      o_clear     <= 1'b0;
      o_mode_sel  <= 2'b00;
      o_err_cnt   <= 8'h00;
    end else begin
      o_sec_plus  <= 1'b0;
      o_min_plus  <= 1'b0;
      o_hour_plus <= 1'b0;
      o_run       <= 1'b0;
      o_stop      <= 1'b0;
      o_clear     <= 1'b0;
      if (uart.i_rx_done) begin
        unique case (1'b1)
          op == OP_SEC:   o_sec_plus  <= 1'b1;
          op == OP_MIN:   o_min_plus  <= 1'b1;
          op == OP_HOUR:  o_hour_plus <= 1'b1;
          op == OP_RUN:   o_run       <= 1'b1;
          op == OP_STOP:  o_stop      <= 1'b1;
          op == OP_CLEAR: o_clear     <= 1'b1;
          op == OP_WMODE: o_mode_sel[1] <= ~o_mode_sel[1];
          op == OP_FMODE: o_mode_sel[0] <= ~o_mode_sel[0];
          op == OP_NONE: begin
            if (o_err_cnt != 8'hFF)
              o_err_cnt <= o_err_cnt + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  cmd_echo_ctrl #(
    .ECHO_EN (ECHO_EN)
  ) u_echo (
    .clk      (clk),
    .rst      (rst),
    .req      (uart.i_rx_done),
    .req_byte (echo_byte),
    .tx_busy  (uart.i_tx_busy),
    .tx_data  (uart.o_tx_data),
    .tx_start (uart.o_tx_start)
  );

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder, echo on and off.
// Expected values are hand-computed from the command map.
module tb_uart_cmd_decoder;
  import uart_cmd_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_decoder_if u_if ();
  uart_cmd_decoder_if n_if ();

  logic       sec_p, min_p, hour_p, run_p, stop_p, clr_p;
  logic [1:0] mode;
  logic [7:0] err;
  logic       n_sec, n_min, n_hour, n_run, n_stop, n_clr;
  logic [1:0] n_mode;
  logic [7:0] n_err;
  logic [5:0] pv, npv;

  assign pv  = {sec_p, min_p, hour_p, run_p, stop_p, clr_p};
  assign npv = {n_sec, n_min, n_hour, n_run, n_stop, n_clr};

  uart_cmd_decoder u_dut (
    .clk         (clk),
    .rst         (rst),
    .uart        (u_if),
    .o_sec_plus  (sec_p),
    .o_min_plus  (min_p),
    .o_hour_plus (hour_p),
    .o_run       (run_p),
    .o_stop      (stop_p),
    .o_clear     (clr_p),
    .o_mode_sel  (mode),
    .o_err_cnt   (err)
  );

  uart_cmd_decoder #(
    .ECHO_EN (1'b0)
  ) u_noecho (
    .clk         (clk),
    .rst         (rst),
    .uart        (n_if),
    .o_sec_plus  (n_sec),
    .o_min_plus  (n_min),
    .o_hour_plus (n_hour),
    .o_run       (n_run),
    .o_stop      (n_stop),
    .o_clear     (n_clr),
    .o_mode_sel  (n_mode),
    .o_err_cnt   (n_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    u_if.i_rx_data = b;
    u_if.i_rx_done = 1'b1;
    tick();
    u_if.i_rx_done = 1'b0;
  endtask

  task automatic drain();
    repeat (12) tick();
  endtask

  task automatic wait_start(output bit got, output logic [7:0] d);
    got = 1'b0;
    d = 8'h00;
    for (int i = 0; i < 12 && !got; i++) begin
      if (u_if.o_tx_start) begin
        got = 1'b1;
        d = u_if.o_tx_data;
      end else begin
        tick();
      end
    end
  endtask

  task automatic count_starts(input int cyc, output int c);
    c = 0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (u_if.o_tx_start) c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    u_if.i_rx_done = 1'b0;
    u_if.i_rx_data = 8'h00;
    u_if.i_tx_busy = 1'b0;
    n_if.i_rx_done = 1'b0;
    n_if.i_rx_data = 8'h00;
    n_if.i_tx_busy = 1'b0;
    repeat (3) tick();
    n_chk++;
    if ({pv, u_if.o_tx_start} !== 7'b0) begin
      $display("FAIL reset_pulses: got %b expected 0", {pv, u_if.o_tx_start});
      n_fail++;
    end
    n_chk++;
    if ({u_if.o_tx_data, mode, err} !== 18'h0) begin
      $display("FAIL reset_regs: got %h/%b/%h expected 0", u_if.o_tx_data, mode, err);
      n_fail++;
    end
    n_chk++;
    if ({npv, n_mode, n_err} !== 16'h0) begin
      $display("FAIL reset_noecho: got %b/%b/%h expected 0", npv, n_mode, n_err);
      n_fail++;
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_run();
    bit got;
    logic [7:0] d;
    int c;
    repeat (8) tick();
    send(CMD_RUN);
    n_chk++;
    if (pv !== 6'b000100) begin
      $display("FAIL run_pulse: got %b expected 000100", pv);
      n_fail++;
    end
    tick();
    n_chk++;
    if (pv !== 6'b000000) begin
      $display("FAIL run_pulse_end: got %b expected 000000", pv);
      n_fail++;
    end
    wait_start(got, d);
    n_chk++;
    if (!got || d !== 8'h52) begin
      $display("FAIL run_echo: got start=%0d data=%h expected 1/52", got, d);
      n_fail++;
    end
    count_starts(8, c);
    n_chk++;
    if (c != 0) begin
      $display("FAIL run_one_start: got %0d extra starts expected 0", c);
      n_fail++;
    end
    drain();
  endtask

  task automatic test_mode();
    send(CMD_WMODE);
    n_chk++;
    if (mode !== 2'b10 || pv !== 6'b0) begin
      $display("FAIL mode_w: got %b/%b expected 10/000000", mode, pv);
      n_fail++;
    end
    send(CMD_FMODE);
    n_chk++;
    if (mode !== 2'b11) begin
      $display("FAIL mode_f: got %b expected 11", mode);
      n_fail++;
    end
    send(CMD_WMODE);
    n_chk++;
    if (mode !== 2'b01) begin
      $display("FAIL mode_w2: got %b expected 01", mode);
      n_fail++;
    end
    drain();
  endtask

  task automatic test_err();
    bit got;
    logic [7:0] d;
    send(8'h78);
    n_chk++;
    if (pv !== 6'b0 || err !== 8'd1 || mode !== 2'b01) begin
      $display("FAIL err_first: got %b/%0d/%b expected 000000/1/01", pv, err, mode);
      n_fail++;
    end
    tick();
    wait_start(got, d);
    n_chk++;
    if (!got || d !== 8'h3F) begin
      $display("FAIL err_echo: got start=%0d data=%h expected 1/3f", got, d);
      n_fail++;
    end
    drain();
    repeat (253) send(8'h78);
    n_chk++;
    if (err !== 8'd254) begin
      $display("FAIL err_254: got %0d expected 254", err);
      n_fail++;
    end
    repeat (46) send(8'h00);
    n_chk++;
    if (err !== 8'd255) begin
      $display("FAIL err_sat: got %0d expected 255", err);
      n_fail++;
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bit got;
    logic [7:0] d;
    int c;
    u_if.i_tx_busy = 1'b1;
    u_if.i_rx_done = 1'b1;
    u_if.i_rx_data = CMD_SEC;
    tick();
    n_chk++;
    if (pv !== 6'b100000) begin
      $display("FAIL b2b_sec: got %b expected 100000", pv);
      n_fail++;
    end
    u_if.i_rx_data = CMD_MIN;
    tick();
    n_chk++;
    if (pv !== 6'b010000) begin
      $display("FAIL b2b_min: got %b expected 010000", pv);
      n_fail++;
    end
    u_if.i_rx_data = CMD_HOUR;
    tick();
    n_chk++;
    if (pv !== 6'b001000) begin
      $display("FAIL b2b_hour: got %b expected 001000", pv);
      n_fail++;
    end
    u_if.i_rx_done = 1'b0;
    tick();
    n_chk++;
    if (pv !== 6'b0) begin
      $display("FAIL b2b_end: got %b expected 000000", pv);
      n_fail++;
    end
    count_starts(5, c);
    n_chk++;
    if (c != 0) begin
      $display("FAIL b2b_busy_start: got %0d starts expected 0", c);
      n_fail++;
    end
    u_if.i_tx_busy = 1'b0;
    tick();
    wait_start(got, d);
    n_chk++;
    if (!got || d !== 8'h73) begin
      $display("FAIL b2b_echo: got start=%0d data=%h expected 1/73", got, d);
      n_fail++;
    end
    tick();
    u_if.i_tx_busy = 1'b1;
    repeat (2) tick();
    n_chk++;
    if (u_if.o_tx_data !== 8'h73) begin
      $display("FAIL b2b_hold_data: got %h expected 73", u_if.o_tx_data);
      n_fail++;
    end
    u_if.i_tx_busy = 1'b0;
    count_starts(10, c);
    n_chk++;
    if (c != 0) begin
      $display("FAIL b2b_dropped: got %0d starts expected 0", c);
      n_fail++;
    end
  endtask

  task automatic test_mid_reset();
    bit got;
    logic [7:0] d;
    int c;
    send(CMD_RUN);
    tick();
    wait_start(got, d);
    n_chk++;
    if (!got) begin
      $display("FAIL mr_start: got no start expected one");
      n_fail++;
    end
    u_if.i_rx_data = CMD_STOP;
    u_if.i_rx_done = 1'b1;
    tick();
    n_chk++;
    if (pv !== 6'b000010) begin
      $display("FAIL mr_stop: got %b expected 000010", pv);
      n_fail++;
    end
    rst = 1'b0;
    u_if.i_rx_data = CMD_FMODE;
    tick();
    u_if.i_rx_done = 1'b0;
    n_chk++;
    if ({pv, u_if.o_tx_start, u_if.o_tx_data, mode, err} !== 25'h0) begin
      $display("FAIL mr_outputs: got %b/%b/%h/%b/%h expected 0",
               pv, u_if.o_tx_start, u_if.o_tx_data, mode, err);
      n_fail++;
    end
    n_chk++;
    if (u_dut.u_echo.state_q !== ECHO_IDLE || u_dut.u_echo.pend_v !== 1'b0) begin
      $display("FAIL mr_fsm: got %0d/%b expected idle/0",
               u_dut.u_echo.state_q, u_dut.u_echo.pend_v);
      n_fail++;
    end
    rst = 1'b1;
    count_starts(12, c);
    n_chk++;
    if (c != 0) begin
      $display("FAIL mr_no_start: got %0d starts expected 0", c);
      n_fail++;
    end
  endtask

  task automatic test_echo_off();
    int c;
    c = 0;
    n_if.i_rx_data = CMD_CLEAR;
    n_if.i_rx_done = 1'b1;
    tick();
    n_if.i_rx_done = 1'b0;
    if (n_if.o_tx_start) c++;
    n_chk++;
    if (npv !== 6'b000001) begin
      $display("FAIL off_clear: got %b expected 000001", npv);
      n_fail++;
    end
    tick();
    if (n_if.o_tx_start) c++;
    n_chk++;
    if (npv !== 6'b0) begin
      $display("FAIL off_clear_end: got %b expected 000000", npv);
      n_fail++;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (n_if.o_tx_start) c++;
    end
    n_chk++;
    if (c != 0 || n_if.o_tx_data !== 8'h00) begin
      $display("FAIL off_tx: got %0d starts data %h expected 0/00", c, n_if.o_tx_data);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_mode();
    test_err();
    test_back_to_back();
    test_mid_reset();
    test_echo_off();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Upstream control stage for the watch/stopwatch display top. Consumes bytes from the UART receiver and decodes single-character ASCII commands into one-cycle control pulses for the watch and the stopwatch (sec/min/hour plus, run, stop, clear). It also holds a registered 2-bit mode select and echoes each accepted byte back through the UART transmitter using a busy/start handshake.

Parameters:
ECHO_EN, 1, 1 = echo/acknowledge path enabled; 0 = tx outputs tied low and the echo FSM stays in IDLE.
ERR_CHAR, 8'h3F, byte echoed for an unrecognised command ('?').

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (0 = reset)
i_rx_data  input  8  received byte; valid only in the cycle i_rx_done=1
i_rx_done  input  1  one-cycle strobe from the UART receiver
i_tx_busy  input  1  UART transmitter busy
o_tx_data  output  8  byte to transmit; held stable from o_tx_start until busy falls
o_tx_start  output  1  one-cycle transmit request
o_sec_plus  output  1  watch second increment pulse
o_min_plus  output  1  watch minute increment pulse
o_hour_plus  output  1  watch hour increment pulse
o_run  output  1  stopwatch run pulse
o_stop  output  1  stopwatch stop pulse
o_clear  output  1  stopwatch clear pulse
o_mode_sel  output  2  [1] = watch(0)/stopwatch(1), [0] = fnd display mode
o_err_cnt  output  8  count of unrecognised bytes, saturating

Behaviour:
- Reset (rst=0 at a clk edge): all pulse outputs 0, o_tx_start 0, o_tx_data 8'h00, o_mode_sel 2'b00, o_err_cnt 0, echo FSM to IDLE, pending flag cleared. Reset wins over any same-cycle rx_done.
- Command map is case-sensitive ASCII:
  - 's'(73h) -> sec_plus; 'm'(6Dh) -> min_plus; 'h'(68h) -> hour_plus.
  - 'R'(52h) -> run; 'S'(53h) -> stop; 'C'(43h) -> clear.
  - 'W'(57h) toggles o_mode_sel[1]; 'F'(46h) toggles o_mode_sel[0].
  - Any other byte is unrecognised.
- Decode latency: i_rx_done high in cycle N -> the matching pulse is high in cycle N+1 only. Pulses are registered and mutually exclusive. o_mode_sel updates at the N+1 edge.
- Back-to-back rx_done in consecutive cycles: each byte is decoded independently and no command is lost.
- Unrecognised byte: no pulse and no mode change. o_err_cnt increments in N+1 and saturates at 255.
- Echo path when ECHO_EN=1:
  - Each decoded byte produces an echo request. The echo byte is the received byte for a valid command and ERR_CHAR otherwise.
  - Echo requests are buffered in a one-entry pending register.
  - If the pending register is full when a new request arrives, the new echo is dropped. The command itself still executes.
- Echo FSM states: IDLE, WAIT_FREE, START, HOLD.
  - IDLE -> WAIT_FREE when pending=1.
  - WAIT_FREE -> START when i_tx_busy=0; o_tx_data is loaded from pending and pending is cleared.
  - START: o_tx_start=1 for exactly one cycle -> HOLD.
  - HOLD -> IDLE when i_tx_busy has been seen high and then low. If busy never rises within 4 cycles of START, return to IDLE (transmitter missed the start).
- o_tx_start is never asserted while i_tx_busy=1.
- Mid-operation reset: the echo in flight is abandoned and o_tx_start deasserts immediately. The stopwatch downstream is reset separately.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - the command byte localparams (CMD_SEC, CMD_MIN, CMD_HOUR, CMD_RUN, CMD_STOP, CMD_CLEAR, CMD_WMODE, CMD_FMODE);
  - the echo FSM state encodings;
  - ERR_CHAR.
- One natural sub-module, cmd_echo_ctrl, contains the pending register, the echo FSM and the tx handshake. The top contains the decoder, the mode register and the error counter.

Test Plan:
- Reset then rx 'R' in cycle 10 -> o_run=1 only in cycle 11, all other pulses 0. Echo o_tx_data=52h with one o_tx_start after busy=0.
- Rx 'W' then 'F' -> o_mode_sel 00 -> 10 -> 11. Rx 'W' again -> 01.
- Rx 'x'(78h) -> no pulse, o_err_cnt=1, echo 3Fh. After 300 bad bytes, o_err_cnt=255.
- Hold i_tx_busy=1 and rx 's','m','h' in consecutive cycles -> three pulses in three consecutive cycles. Only 73h is echoed after busy falls; the other two echoes are dropped.
- Apply rst=0 during START/HOLD with pending=1 -> next cycle all outputs at reset values, FSM IDLE, no o_tx_start afterwards.
- ECHO_EN=0: rx 'C' -> o_clear pulse in N+1, o_tx_start stays 0 throughout.
